// File: rtl/sys_dbg_pkg.sv
// Shared types and constants for the debug dump engine: FSM states, record/tag
// layout and the helpers that build record tags.
package sys_dbg_pkg;

  localparam int unsigned REC_W = 32;
  localparam int unsigned TAG_W = 8;

  localparam logic TAG_REG = 1'b0;
  localparam logic TAG_LED = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG_WAIT,
    S_REG_SEND,
    S_LED_WAIT,
    S_LED_SEND,
    S_DONE
  } state_t;

  function automatic logic [TAG_W-1:0] reg_tag(input logic [4:0] addr);
    return {TAG_REG, 2'b00, addr};
  endfunction

  function automatic logic [TAG_W-1:0] led_tag(input logic [2:0] sel);
    return {TAG_LED, 4'b0000, sel};
  endfunction

endpackage

// File: rtl/sys_debug_reader_if.sv
// Valid/ready record stream carrying a captured value plus its tag.
interface sys_debug_reader_if;
  logic                           out_valid;
  logic                           out_ready;
  logic [sys_dbg_pkg::REC_W-1:0]  out_data;
  logic [sys_dbg_pkg::TAG_W-1:0]  out_tag;

  modport master (output out_valid, output out_data, output out_tag, input out_ready);
  modport slave  (input out_valid, input out_data, input out_tag, output out_ready);
endinterface

// File: rtl/sys_dbg_out_reg.sv
// One-entry valid/ready holding register: data and tag stay frozen from load
// until the consumer accepts them.
module sys_dbg_out_reg
  import sys_dbg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [REC_W-1:0] load_data,
  input  logic [TAG_W-1:0] load_tag,
  sys_debug_reader_if.master out,
  output logic             fire
);

  assign fire = out.out_valid && out.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
      out.out_tag   <= '0;
    end else if (load) begin
      out.out_valid <= 1'b1;
      out.out_data  <= load_data;
      out.out_tag   <= load_tag;
    end else if (fire) begin
      out.out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sys_debug_reader.sv
// Sweeps the register-file debug port and then the LED selector, emitting each
// captured value as a tagged record on a back-pressured stream.
module sys_debug_reader
  import sys_dbg_pkg::*;
#(
  parameter int unsigned REG_FIRST = 0,
  parameter int unsigned REG_LAST  = 31,
  parameter int unsigned SEL_COUNT = 8,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        start,
  output logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_val,
  output logic [7:0]  sel,
  input  logic [26:0] leds,
  sys_debug_reader_if.master out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fire;
  logic             cap_en;
  logic [REC_W-1:0] cap_data;
  logic [TAG_W-1:0] cap_tag;

  // Capture happens on the edge where the wait counter steps from 1 to 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    cap_en   = 1'b0;
    cap_data = '0;
    cap_tag  = '0;
    if (cnt == CNT_ONE) begin
      if (state == S_REG_WAIT) begin
        cap_en   = 1'b1;
        cap_data = dbg_val;
        cap_tag  = reg_tag(dbg_addr);
      end else if (state == S_LED_WAIT) begin
        cap_en   = 1'b1;
        cap_data = {5'b00000, leds};
        cap_tag  = led_tag(sel[2:0]);
      end
    end
  end

  sys_dbg_out_reg u_out_reg (
    .clk       (SYS_clk),
    .rst       (SYS_reset),
    .load      (cap_en),
    .load_data (cap_data),
    .load_tag  (cap_tag),
    .out       (out),
    .fire      (fire)
  );

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dbg_addr <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dbg_addr <= 5'(REG_FIRST);
            cnt      <= CNT_INIT;
            busy     <= 1'b1;
            state    <= S_REG_WAIT;
          end
        end
        S_REG_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_REG_SEND;
        end
        S_REG_SEND: begin
          if (fire) begin
            cnt <= CNT_INIT;
            // Compare before incrementing so REG_LAST=31 never wraps the address.
            if (dbg_addr < 5'(REG_LAST)) begin
              dbg_addr <= dbg_addr + 5'd1;
              state    <= S_REG_WAIT;
            end else begin
              sel   <= '0;
              state <= S_LED_WAIT;
            end
          end
        end
        S_LED_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_LED_SEND;
        end
        S_LED_SEND: begin
          if (fire) begin
            if (sel < 8'(SEL_COUNT - 1)) begin
              sel   <= sel + 8'd1;
              cnt   <= CNT_INIT;
              state <= S_LED_WAIT;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_debug_reader.sv
// Directed bench for sys_debug_reader: three configurations share one clock and
// reset, each with its own register-file/LED model and record scoreboard.
module tb_sys_debug_reader;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] data;
  } rec_t;

  logic        SYS_clk;
  logic        SYS_reset;
  int          tests;
  int          fails;

  logic        start0, start1, start2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [4:0]  dbg_addr0, dbg_addr1, dbg_addr2;
  logic [7:0]  sel0, sel1, sel2;
  logic [31:0] dbg_val0, dbg_val1, dbg_val2;
  logic [26:0] leds0, leds1, leds2;
  logic [31:0] perturb0;
  logic [31:0] p1, p2;
  logic [26:0] q1, q2;

  rec_t sb0[$];
  rec_t sb1[$];
  rec_t sb2[$];
  int   n0, n1, n2;

  sys_debug_reader_if if0 ();
  sys_debug_reader_if if1 ();
  sys_debug_reader_if if2 ();

  // Default configuration: register i reads A000_0000+i, optionally disturbed.
  assign dbg_val0 = (32'hA000_0000 + 32'(dbg_addr0)) ^ perturb0;
  assign leds0    = 27'h123_4560 ^ 27'(sel0);

  // Single-register configuration.
  assign dbg_val1 = (dbg_addr1 == 5'd8) ? 32'h0000_002A : (32'hDEAD_BEE0 | 32'(dbg_addr1));
  assign leds1    = 27'h7FF_FFFF;

  // Slow register file: value settles two edges after the address changes.
  always @(posedge SYS_clk) begin
    p1 <= 32'hB000_0000 + 32'h111 * 32'(dbg_addr2);
    p2 <= p1;
    q1 <= 27'h2AB_C000 | 27'(sel2);
    q2 <= q1;
  end
  assign dbg_val2 = p2;
  assign leds2    = q2;

  sys_debug_reader dut0 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .start(start0),
    .dbg_addr(dbg_addr0), .dbg_val(dbg_val0), .sel(sel0), .leds(leds0),
    .out(if0), .busy(busy0), .done(done0)
  );

  sys_debug_reader #(.REG_FIRST(8), .REG_LAST(8), .SEL_COUNT(1), .READ_LAT(1)) dut1 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .start(start1),
    .dbg_addr(dbg_addr1), .dbg_val(dbg_val1), .sel(sel1), .leds(leds1),
    .out(if1), .busy(busy1), .done(done1)
  );

  sys_debug_reader #(.REG_FIRST(28), .REG_LAST(31), .SEL_COUNT(8), .READ_LAT(3)) dut2 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .start(start2),
    .dbg_addr(dbg_addr2), .dbg_val(dbg_val2), .sel(sel2), .leds(leds2),
    .out(if2), .busy(busy2), .done(done2)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  function automatic logic [31:0] exp_led0(input int s);
    logic [26:0] l;
    l = 27'h123_4560 ^ 27'(s);
    return {5'b00000, l};
  endfunction

  function automatic logic [31:0] exp_led2(input int s);
    logic [26:0] l;
    l = 27'h2AB_C000 | 27'(s);
    return {5'b00000, l};
  endfunction

  // Monitors sample on the falling edge; inputs change just after rising edges.
  logic        hold0;
  logic [7:0]  htag0;
  logic [31:0] hdata0;

  always @(negedge SYS_clk) begin
    rec_t e;
    if (SYS_reset) begin
      hold0 = 1'b0;
    end else begin
      if (hold0)
        check("hold0_stable", 64'({if0.out_valid, if0.out_tag, if0.out_data}),
              64'({1'b1, htag0, hdata0}));
      if (if0.out_valid && if0.out_ready) begin
        check("rec0_expected", 64'(sb0.size() != 0), 64'd1);
        if (sb0.size() != 0) begin
          e = sb0.pop_front();
          check("rec0_tag", 64'(if0.out_tag), 64'(e.tag));
          check("rec0_data", 64'(if0.out_data), 64'(e.data));
        end
        n0++;
      end
      hold0  = if0.out_valid && !if0.out_ready;
      htag0  = if0.out_tag;
      hdata0 = if0.out_data;
    end
  end

  always @(negedge SYS_clk) begin
    rec_t e;
    if (!SYS_reset && if1.out_valid && if1.out_ready) begin
      check("rec1_expected", 64'(sb1.size() != 0), 64'd1);
      if (sb1.size() != 0) begin
        e = sb1.pop_front();
        check("rec1_tag", 64'(if1.out_tag), 64'(e.tag));
        check("rec1_data", 64'(if1.out_data), 64'(e.data));
      end
      n1++;
    end
  end

  always @(negedge SYS_clk) begin
    rec_t e;
    if (!SYS_reset && if2.out_valid && if2.out_ready) begin
      check("rec2_expected", 64'(sb2.size() != 0), 64'd1);
      if (sb2.size() != 0) begin
        e = sb2.pop_front();
        check("rec2_tag", 64'(if2.out_tag), 64'(e.tag));
        check("rec2_data", 64'(if2.out_data), 64'(e.data));
      end
      n2++;
    end
  end

  task automatic push_default0();
    for (int i = 0; i < 32; i++) sb0.push_back('{tag: 8'(i), data: 32'hA000_0000 + 32'(i)});
    for (int s = 0; s < 8; s++) sb0.push_back('{tag: 8'h80 | 8'(s), data: exp_led0(s)});
  endtask

  task automatic wait_done0(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done0 && cyc < 1000);
  endtask

  task automatic check_reset0(input string name);
    check({name, "_addr"},  64'(dbg_addr0), 64'd0);
    check({name, "_sel"},   64'(sel0), 64'd0);
    check({name, "_valid"}, 64'(if0.out_valid), 64'd0);
    check({name, "_data"},  64'(if0.out_data), 64'd0);
    check({name, "_tag"},   64'(if0.out_tag), 64'd0);
    check({name, "_busy"},  64'(busy0), 64'd0);
    check({name, "_done"},  64'(done0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    logic saw_done;

    tests = 0; fails = 0; n0 = 0; n1 = 0; n2 = 0;
    SYS_reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    perturb0 = '0;
    if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;
    tick(); tick();
    check_reset0("reset0");
    SYS_reset = 1'b0;
    tick();

    // Default full sweep, consumer always ready: 40 records, done 80 cycles on.
    push_default0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("sweep0_busy", 64'(busy0), 64'd1);
    wait_done0(cyc);
    check("sweep0_cycles", 64'(cyc), 64'd80);
    check("sweep0_busy_at_done", 64'(busy0), 64'd0);
    check("sweep0_drained", 64'(sb0.size()), 64'd0);
    check("sweep0_records", 64'(n0), 64'd40);
    tick();
    check("sweep0_done_width", 64'(done0), 64'd0);

    // Back-pressure: stall the first record 5 cycles while dbg_val wiggles.
    push_default0();
    if0.out_ready = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    k = 0;
    while (!if0.out_valid && k < 20) begin tick(); k++; end
    check("stall_valid_seen", 64'(if0.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      perturb0 = $urandom;
      tick();
    end
    check("stall_data", 64'(if0.out_data), 64'hA000_0000);
    check("stall_tag", 64'(if0.out_tag), 64'h00);
    perturb0 = '0;
    cyc = 0;
    do begin
      if0.out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end while (!done0 && cyc < 2000);
    check("stall_done_seen", 64'(done0), 64'd1);
    check("stall_drained", 64'(sb0.size()), 64'd0);
    check("stall_records", 64'(n0), 64'd80);
    if0.out_ready = 1'b1;
    tick();

    // Reset in the middle of record 5 aborts everything, no done pulse.
    push_default0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    k = 0;
    while (!(if0.out_valid && if0.out_tag == 8'h05) && k < 100) begin tick(); k++; end
    check("abort_rec5_reached", 64'({if0.out_valid, if0.out_tag}), 64'h105);
    SYS_reset = 1'b1;
    #1;
    check_reset0("abort");
    sb0.delete();
    tick();
    SYS_reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw_done = saw_done | done0 | busy0;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    check("abort_records", 64'(n0), 64'd85);
    push_default0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done0(cyc);
    check("restart_cycles", 64'(cyc), 64'd80);
    check("restart_drained", 64'(sb0.size()), 64'd0);

    // Single register + single LED, start held through the sweep and DONE.
    sb1.push_back('{tag: 8'h08, data: 32'h0000_002A});
    sb1.push_back('{tag: 8'h80, data: 32'h07FF_FFFF});
    start1 = 1'b1;
    tick();
    check("held_busy", 64'(busy1), 64'd1);
    cyc = 0;
    do begin tick(); cyc++; end while (!done1 && cyc < 100);
    check("held_cycles", 64'(cyc), 64'd4);
    check("held_records", 64'(n1), 64'd2);
    tick();
    check("held_done_ignored", 64'({busy1, done1}), 64'd0);
    check("held_drained", 64'(sb1.size()), 64'd0);
    sb1.push_back('{tag: 8'h08, data: 32'h0000_002A});
    sb1.push_back('{tag: 8'h80, data: 32'h07FF_FFFF});
    tick();
    start1 = 1'b0;
    check("held_restart_busy", 64'(busy1), 64'd1);
    cyc = 0;
    do begin tick(); cyc++; end while (!done1 && cyc < 100);
    check("held2_cycles", 64'(cyc), 64'd4);
    check("held2_records", 64'(n1), 64'd4);
    check("held2_drained", 64'(sb1.size()), 64'd0);

    // READ_LAT=3 against a two-cycle register file, registers 28..31.
    for (int a = 28; a < 32; a++)
      sb2.push_back('{tag: 8'(a), data: 32'hB000_0000 + 32'h111 * 32'(a)});
    for (int s = 0; s < 8; s++) sb2.push_back('{tag: 8'h80 | 8'(s), data: exp_led2(s)});
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (!done2 && cyc < 1000);
    check("slow_cycles", 64'(cyc), 64'd48);
    check("slow_records", 64'(n2), 64'd12);
    check("slow_drained", 64'(sb2.size()), 64'd0);
    check("slow_addr_hold", 64'(dbg_addr2), 64'd31);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sys_debug_reader.md
# sys_debug_reader

Hardware counterpart to the bench-side observation of `system`: it drives the register-file debug read port (`test_address_register` / `test_value_register`) and the LED output selector (`SYS_output_sel` / `SYS_leds`). It sweeps a configured register range and then every LED selector value, captures each result and emits it as a tagged 32-bit record on a valid/ready stream (UART/ILA feed). This replaces `$monitor`-style polling with a synthesizable, back-pressure-aware dump engine.

## Interface
- `REG_FIRST`, default 0: first register address swept (0..31).
- `REG_LAST`, default 31: last register address swept (REG_FIRST..31).
- `SEL_COUNT`, default 8: number of LED selector values swept, 0..SEL_COUNT-1 (1..8).
- `READ_LAT`, default 1: edges between driving an address/selector and sampling its value (>=1).

Ports:
- `SYS_clk` in 1: single clock, rising edge.
- `SYS_reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin one sweep; honoured only in IDLE.
- `dbg_addr` out 5: to `test_address_register`.
- `dbg_val` in 32: from `test_value_register`.
- `sel` out 8: to `SYS_output_sel`.
- `leds` in 27: from `SYS_leds`.
- `out_valid` out 1: record available.
- `out_ready` in 1: consumer accepts the record.
- `out_data` out 32: register value, or `{5'b0, leds}`.
- `out_tag` out 8: bit 7 = 0 register / 1 LED; bits 6:0 = address or selector.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at end of sweep.

## Operation
- States: IDLE, REG_WAIT, REG_SEND, LED_WAIT, LED_SEND, DONE.
- IDLE with `start`=1 at an edge: `dbg_addr`<=REG_FIRST, wait counter<=READ_LAT, `busy`<=1, go to REG_WAIT.
- REG_WAIT decrements the counter each edge. On the edge where it reaches 0:
  - `out_data`<=`dbg_val`, `out_tag`<={1'b0, 2'b0, addr}, `out_valid`<=1.
  - Go to REG_SEND.
- REG_SEND holds `out_data`/`out_tag`/`out_valid` stable until `out_valid`&&`out_ready` at an edge. On that edge:
  - If addr<REG_LAST: addr+1, counter reload, go to REG_WAIT.
  - Else: `sel`<=0, counter reload, go to LED_WAIT.
  - `out_valid` drops on that edge.
- LED_WAIT / LED_SEND behave the same way:
  - Capture is `{5'b0, leds}`, tag {1'b1, 4'b0, sel[2:0]}.
  - Advance while sel<SEL_COUNT-1; after the last handshake go to DONE.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE, including in DONE.
- `dbg_addr` and `sel` hold their last value in IDLE.
- No address wrap: addr never increments past REG_LAST. The 5-bit counter must not overflow when REG_LAST=31; compare before incrementing.

## Timing
- Reset values: `dbg_addr`=0, `sel`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Reset mid-sweep aborts immediately (asynchronous):
  - Any pending record is dropped.
  - No `done` pulse.
- Address/selector change to capture: READ_LAT edges.
- Per-record cost with `out_ready` held high: READ_LAT+1 cycles.
- Full sweep: N=(REG_LAST-REG_FIRST+1)+SEL_COUNT records. The `done` pulse appears in the cycle after the last handshake edge.
  - Defaults: 40 records, 80 cycles from the start edge to the `done` cycle.
- `out_ready` may toggle arbitrarily; data must not change while `out_valid`=1 and no handshake has occurred.
- `out_ready` high before `out_valid`: no combinational path from `out_ready` to `out_valid`/`out_data`.
- All outputs are registered.

## Structure
- Package `sys_dbg_pkg`:
  - state enum;
  - tag constants TAG_REG=1'b0, TAG_LED=1'b1;
  - record width 32, tag width 8.
- One sub-module, `sys_dbg_out_reg`: a one-entry valid/ready holding register for data+tag.
- The FSM, wait counter and address/selector counters stay in the top.

## Test plan
- Defaults; register i holds 32'hA000_0000+i; `out_ready`=1; pulse `start` -> 32 records with tag 8'h00..8'h1F and data A000_0000..A000_001F, then 8 records with tag 8'h80..8'h87. `done` pulse 80 cycles after the start edge.
- REG_FIRST=8, REG_LAST=8, SEL_COUNT=1; reg 8 = 32'h0000_002A; `leds`=27'h7FF_FFFF -> records (8'h08, 32'h2A), then (8'h80, 32'h07FF_FFFF), then `done`.
- `out_ready` low for 5 cycles while `out_valid`=1, with `dbg_val` changing meanwhile -> `out_data`/`out_tag` unchanged. One handshake, no duplicated or skipped record.
- `start` held high through the sweep and the DONE cycle -> exactly one sweep. A new sweep starts only from IDLE on the following edge.
- `SYS_reset` asserted during record 5 -> outputs at reset values within the same cycle, no `done`. A later `start` restarts from REG_FIRST.
- READ_LAT=3, model register file with 2-cycle read delay -> captured values match the settled values, never the stale ones.
